// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the handshaked data memory.
// Holds:
// - the access-size encodings (funct3[1:0]);
// - the FSM state encoding;
// - the maximum wait latency;
// - helpers that classify an access and build its byte-lane mask.
package riscv_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  // Misaligned half/word or the reserved size code.
  function automatic logic acc_err(input logic [1:0] size, input logic [1:0] a_lo);
    logic e;
    case (size)
      SZ_B:    e = 1'b0;
      SZ_H:    e = a_lo[0];
      SZ_W:    e = |a_lo;
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Byte lanes written by a store of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a_lo);
    logic [3:0] m;
    case (size)
      SZ_B:    m = 4'b0001 << a_lo;
      SZ_H:    m = a_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:    m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_hs_if.sv
// Request/response bundle between a requester and dmem_hs.
// Ports:
// - request side: req, we, a (byte address), wd (right-aligned store data), size, uns;
// - response side: busy, ready (one-cycle strobe), rd (load data), err.
interface dmem_hs_if;
  logic        req;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [1:0]  size;
  logic        uns;
  logic        busy;
  logic        ready;
  logic [31:0] rd;
  logic        err;

  modport master (output req, we, a, wd, size, uns, input busy, ready, rd, err);
  modport slave  (input req, we, a, wd, size, uns, output busy, ready, rd, err);
endinterface

// File: rtl/loadext.sv
// Load alignment and extension.
// Picks the addressed byte or half out of a memory word, then sign- or
// zero-extends it to 32 bits. Word loads pass through unchanged.
// Ports:
// - word_i: memory word;
// - a_lo_i: byte offset;
// - size_i: access size;
// - uns_i: 1 = zero-extend;
// - result_o: aligned, extended value.
module loadext
  import riscv_mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  a_lo_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension.
  always_comb begin
    byte_s   = 8'h00;
    half_s   = 16'h0000;
    result_o = 32'h0000_0000;
    case (a_lo_i)
      2'd0:    byte_s = word_i[7:0];
      2'd1:    byte_s = word_i[15:8];
      2'd2:    byte_s = word_i[23:16];
      2'd3:    byte_s = word_i[31:24];
      default: byte_s = 8'h00;
    endcase
    if (a_lo_i[1]) begin
      half_s = word_i[31:16];
    end else begin
      half_s = word_i[15:0];
    end
    case (size_i)
      SZ_B:    result_o = {{24{~uns_i & byte_s[7]}}, byte_s};
      SZ_H:    result_o = {{16{~uns_i & half_s[15]}}, half_s};
      SZ_W:    result_o = word_i;
      default: result_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dmem_hs.sv
// Single-port data memory behind a req/ready handshake.
// An accepted access waits LATENCY cycles, spends one cycle in RESP, and
// the response (ready, rd, err) is registered out of that cycle. Stores
// commit on the edge leaving RESP.
// Ports:
// - clk: clock;
// - reset: synchronous, active high;
// - bus: dmem_hs_if slave.
module dmem_hs
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_hs_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY_MAX + 1);
  localparam logic [CW-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CW'(LATENCY - 1);

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW+1:0] a_q;
  logic [31:0]   wd_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          busy_q;
  logic          ready_q;
  logic          err_q;
  logic [31:0]   rd_q;

  logic [31:0]   mem_q [DEPTH];

  logic [AW-1:0] idx_s;
  logic [31:0]   word_s;
  logic [31:0]   ld_s;
  logic          err_s;
  logic [3:0]    mask_s;
  logic [31:0]   lanes_s;
  logic [31:0]   wword_d;
  logic          accept_s;
  logic          commit_s;
  logic          unused_a_s;

  // Upper address bits do not take part in decoding.
  assign unused_a_s = ^bus.a[31:AW+2];

  assign idx_s    = a_q[AW+1:2];
  assign word_s   = mem_q[idx_s];
  assign err_s    = acc_err(size_q, a_q[1:0]);
  assign mask_s   = lane_mask(size_q, a_q[1:0]);
  assign accept_s = bus.req & ((state_q == ST_IDLE) | (state_q == ST_RESP));
  // A reset on the leaving edge drops the pending store.
  assign commit_s = (state_q == ST_RESP) & we_q & ~err_s & ~reset;

  // Replicate right-aligned store data across every lane.
  // The mask then keeps only the lanes that are addressed.
  always_comb begin
    lanes_s = 32'h0000_0000;
    case (size_q)
      SZ_B:    lanes_s = {4{wd_q[7:0]}};
      SZ_H:    lanes_s = {2{wd_q[15:0]}};
      default: lanes_s = wd_q;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (mask_s[i]) begin
        wword_d[8*i +: 8] = lanes_s[8*i +: 8];
      end else begin
        wword_d[8*i +: 8] = word_s[8*i +: 8];
      end
    end
  end

  loadext u_loadext (
    .word_i   (word_s),
    .a_lo_i   (a_q[1:0]),
    .size_i   (size_q),
    .uns_i    (uns_q),
    .result_o (ld_s)
  );

  // Handshake FSM, latency counter and registered response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      rd_q    <= 32'h0000_0000;
    end else begin
      ready_q <= (state_q == ST_RESP);
      err_q   <= (state_q == ST_RESP) & err_s;
      rd_q    <= ((state_q == ST_RESP) && !we_q && !err_s) ? ld_s : 32'h0000_0000;
      case (state_q)
        ST_IDLE, ST_RESP: begin
          if (accept_s) begin
            a_q    <= bus.a[AW+1:0];
            wd_q   <= bus.wd;
            we_q   <= bus.we;
            size_q <= bus.size;
            uns_q  <= bus.uns;
            cnt_q  <= CNT_LOAD;
            busy_q <= 1'b1;
            state_q <= (LATENCY == 0) ? ST_RESP : ST_WAIT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          busy_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Store port; memory contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_s) begin
      mem_q[idx_s] <= wword_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.rd    = rd_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_dmem_hs.sv
// Scoreboard bench for dmem_hs.
// - Two instances: LATENCY=2 (dut0) and LATENCY=0 (dut1), DEPTH=64.
// - The reference is a byte-addressed array model; expected responses are
//   queued at accept time and checked by an independent monitor.
module tb_dmem_hs;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_hs_if b2();
  dmem_hs_if b0();

  dmem_hs #(.DEPTH(64), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(b2.slave));
  dmem_hs #(.DEPTH(64), .LATENCY(0)) u_l0 (.clk(clk), .reset(reset), .bus(b0.slave));

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        q2[$];
  exp_t        q0[$];
  logic [7:0]  mb [2][256];
  int          cyc = 0;
  int          checks = 0;
  int          passed = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: memory is 256 bytes, addresses wrap, little-endian.
  task automatic model(int w, bit we, logic [31:0] a, logic [31:0] wd, logic [1:0] size,
                       bit uns, output logic [31:0] rd, output bit err);
    int nb;
    logic [31:0] v;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err = (size == 2'd3) || ((a % nb) != 0);
    rd = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < nb; i++) mb[w][(a + i) & 255] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = mb[w][(a + i) & 255];
        if (!uns && nb < 4 && v[8*nb-1]) for (int i = 8*nb; i < 32; i++) v[i] = 1'b1;
        rd = v;
      end
    end
  endtask

  task automatic drive(int w, bit rq, bit we, logic [31:0] a, logic [31:0] wd,
                       logic [1:0] size, bit uns);
    if (w == 0) begin
      b2.req = rq; b2.we = we; b2.a = a; b2.wd = wd; b2.size = size; b2.uns = uns;
    end else begin
      b0.req = rq; b0.we = we; b0.a = a; b0.wd = wd; b0.size = size; b0.uns = uns;
    end
  endtask

  task automatic set_req(int w, bit rq);
    if (w == 0) b2.req = rq;
    else b0.req = rq;
  endtask

  task automatic gap(int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one access.
  // - abort_k in 1..lat: reset hits the k-th WAIT edge.
  // - abort_k = lat+1: reset hits the edge leaving RESP.
  // - noise: hold a bogus request high through WAIT.
  // Returns in the RESP cycle (or idle after an abort).
  task automatic issue(int w, bit we, logic [31:0] a, logic [31:0] wd, logic [1:0] size,
                       bit uns, int abort_k, bit noise);
    int lat;
    exp_t e;
    logic [31:0] r;
    bit er;
    lat = (w == 0) ? 2 : 0;
    drive(w, 1'b1, we, a, wd, size, uns);
    @(posedge clk); #1;
    if (abort_k == 0) begin
      model(w, we, a, wd, size, uns, r, er);
      e.rd = r; e.err = er; e.cyc = cyc + 1 + lat;
      if (w == 0) q2.push_back(e);
      else q0.push_back(e);
    end
    if (noise && lat > 0 && abort_k == 0) drive(w, 1'b1, 1'b1, a ^ 32'h4, $urandom, 2'd2, 1'b0);
    else set_req(w, 1'b0);
    for (int k = 1; k <= lat; k++) begin
      if (abort_k == k) reset = 1'b1;
      @(posedge clk); #1;
      if (abort_k == k) begin
        reset = 1'b0;
        @(negedge clk);
        chk($sformatf("busy_after_abort_wait_dut%0d", w), {31'b0, (w == 0) ? b2.busy : b0.busy}, 32'h0);
      end
    end
    set_req(w, 1'b0);
    if (abort_k == lat + 1) begin
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk($sformatf("busy_after_abort_resp_dut%0d", w), {31'b0, (w == 0) ? b2.busy : b0.busy}, 32'h0);
    end
  endtask

  task automatic mon(int w, logic rdy, logic [31:0] rd, logic err);
    exp_t e;
    if (rdy === 1'b1) begin
      if ((w == 0 && q2.size() == 0) || (w == 1 && q0.size() == 0)) begin
        checks++;
        $display("FAIL unexpected_ready_dut%0d: got ready=1 rd=%h err=%b, want no response", w, rd, err);
      end else begin
        if (w == 0) e = q2.pop_front();
        else e = q0.pop_front();
        chk($sformatf("rd_dut%0d", w), rd, e.rd);
        chk($sformatf("err_dut%0d", w), {31'b0, err}, {31'b0, e.err});
        chk($sformatf("latency_dut%0d", w), 32'(cyc), 32'(e.cyc));
      end
    end else if (rdy === 1'b0) begin
      chk($sformatf("quiet_rd_err_dut%0d", w), rd | {31'b0, err}, 32'h0);
    end else begin
      chk($sformatf("ready_known_dut%0d", w), {31'b0, rdy}, 32'h0);
    end
  endtask

  // Response monitor, decoupled from the stimulus.
  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, b2.ready, b2.rd, b2.err);
      mon(1, b0.ready, b0.rd, b0.err);
    end
  end

  initial begin
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'd2, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_dut0", {b2.busy, b2.ready, b2.err, 29'b0} | b2.rd, 32'h0);
    chk("reset_dut1", {b0.busy, b0.ready, b0.err, 29'b0} | b0.rd, 32'h0);
    reset = 1'b0;
    mon_en = 1'b1;
    gap(1);

    // Fill both memories so every model byte is known.
    for (int i = 0; i < 64; i++) issue(0, 1'b1, 32'(4*i), $urandom, 2'd2, 1'b0, 0, 1'b0);
    for (int i = 0; i < 64; i++) issue(1, 1'b1, 32'(4*i), $urandom, 2'd2, 1'b0, 0, 1'b0);
    gap(2);

    // Directed cases on the LATENCY=2 instance.
    issue(0, 1'b1, 32'd100, 32'hDEADBEEF, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd100, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 32'd8, 32'h80F07F01, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd9, 32'h0, 2'd0, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd10, 32'h0, 2'd0, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd10, 32'h0, 2'd1, 1'b1, 0, 1'b0);
    issue(0, 1'b1, 32'd4, 32'hAAAAAAAA, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 32'd6, 32'h00001234, 2'd1, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd4, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd102, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 32'd5, 32'h0000FFFF, 2'd1, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd4, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd16, 32'h0, 2'd3, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 32'd268, 32'hC0FFEE11, 2'd2, 1'b0, 0, 1'b0);
    gap(1);
    issue(0, 1'b0, 32'd12, 32'h0, 2'd2, 1'b0, 0, 1'b0);

    // Reset aborts and ignored requests during WAIT.
    issue(0, 1'b1, 32'd20, 32'h600DF00D, 2'd2, 1'b0, 0, 1'b0);
    gap(1);
    issue(0, 1'b1, 32'd20, 32'hBAD0BAD0, 2'd2, 1'b0, 1, 1'b0);
    issue(0, 1'b0, 32'd20, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 32'd20, 32'hBAD1BAD1, 2'd2, 1'b0, 3, 1'b0);
    issue(0, 1'b0, 32'd20, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b1, 32'd24, 32'h13572468, 2'd2, 1'b0, 0, 1'b1);
    issue(0, 1'b0, 32'd28, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(0, 1'b0, 32'd24, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(1, 1'b1, 32'd44, 32'h0BADCAFE, 2'd2, 1'b0, 1, 1'b0);
    issue(1, 1'b0, 32'd44, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    gap(2);

    // LATENCY=0: back-to-back loads, then store/load to one word.
    for (int i = 0; i < 8; i++) issue(1, 1'b0, 32'(4*i), 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(1, 1'b1, 32'd41, 32'h000000A5, 2'd0, 1'b0, 0, 1'b0);
    issue(1, 1'b0, 32'd40, 32'h0, 2'd2, 1'b0, 0, 1'b0);
    issue(1, 1'b0, 32'd41, 32'h0, 2'd0, 1'b0, 0, 1'b0);
    gap(2);

    // Randomized traffic on both instances.
    for (int n = 0; n < 300; n++) begin
      int w;
      logic [1:0] sz;
      logic [31:0] a;
      w = $urandom_range(0, 1);
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(w, 1'($urandom_range(0, 1)), a, $urandom, sz, 1'($urandom_range(0, 1)), 0,
            1'($urandom_range(0, 3) == 0));
      gap($urandom_range(0, 2));
    end

    gap(6);
    chk("drain_dut0", 32'(q2.size()), 32'h0);
    chk("drain_dut1", 32'(q0.size()), 32'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
